// File: rtl/cond_pkg.sv
// ============================================================================
// Module   : cond_pkg
// Brief    : Condition-code encodings and NZCV flag bit positions shared by the
//            conditional-execution stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage : cond_pkg

`default_nettype wire

// File: rtl/cond_check.sv
// ============================================================================
// Module   : cond_check
// Brief    : Combinational evaluation of a 4-bit condition field against NZCV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[N_IDX];
    assign w_z  = Flags[Z_IDX];
    assign w_c  = Flags[C_IDX];
    assign w_v  = Flags[V_IDX];
    assign w_ge = (w_n == w_v);

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = w_ge;
            COND_LT: CondEx = ~w_ge;
            COND_GT: CondEx = ~w_z & w_ge;
            COND_LE: CondEx = w_z | ~w_ge;
            COND_AL: CondEx = 1'b1;
            // Reserved encoding executes as "never"
            default: CondEx = 1'b0;
        endcase
    end

endmodule : cond_check

`default_nettype wire

// File: rtl/cond_logic.sv
// ============================================================================
// Module   : cond_logic
// Brief    : NZCV flag register, condition gating of PCS/RegW/MemW, and
//            optional saturating event counters (enabled by COND_CNT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_logic
    import cond_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    input  logic [1:0]           FlagW,
    input  logic                 PCS,
    input  logic                 RegW,
    input  logic                 MemW,
    input  logic                 NoWrite,
`ifdef COND_CNT_EN
    input  logic                 CntClear,
    output logic [CNT_WIDTH-1:0] ExecCount,
    output logic [CNT_WIDTH-1:0] SquashCount,
    output logic [CNT_WIDTH-1:0] BranchCount,
`endif
    output logic                 PCSrc,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 CondEx,
    output logic [3:0]           Flags
);

    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("cond_logic: CNT_WIDTH must be at least 1");
    end

    logic [1:0] r_flags_nz;
    logic [1:0] r_flags_cv;
    logic       w_cond_ex;

    assign Flags = {r_flags_nz, r_flags_cv};

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (w_cond_ex)
    );

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS  & w_cond_ex;
    assign RegWrite = RegW & w_cond_ex & ~NoWrite;
    assign MemWrite = MemW & w_cond_ex;

    // Each flag half has its own enable so logical ops can leave C,V intact
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags_nz <= 2'b00;
            r_flags_cv <= 2'b00;
        end else begin
            if (FlagW[1] && w_cond_ex) r_flags_nz <= ALUFlags[3:2];
            if (FlagW[0] && w_cond_ex) r_flags_cv <= ALUFlags[1:0];
        end
    end

`ifdef COND_CNT_EN
    logic [CNT_WIDTH-1:0] r_exec_cnt;
    logic [CNT_WIDTH-1:0] r_squash_cnt;
    logic [CNT_WIDTH-1:0] r_branch_cnt;

    // Counters stick at all-ones; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
            r_branch_cnt <= '0;
        end else if (CntClear) begin
            r_exec_cnt   <= '0;
            r_squash_cnt <= '0;
            r_branch_cnt <= '0;
        end else begin
            if (w_cond_ex && (r_exec_cnt != '1))
                r_exec_cnt <= r_exec_cnt + 1'b1;
            if (!w_cond_ex && (r_squash_cnt != '1))
                r_squash_cnt <= r_squash_cnt + 1'b1;
            if (PCSrc && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 1'b1;
        end
    end

    assign ExecCount   = r_exec_cnt;
    assign SquashCount = r_squash_cnt;
    assign BranchCount = r_branch_cnt;
`endif

endmodule : cond_logic

`default_nettype wire
